// File: rtl/eBike_adc_pkg.sv
// Shared constants and types for the ADC128S SPI converter model.
package eBike_adc_pkg;

    localparam int unsigned ADC_DW     = 12;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned RISE_W     = 5;

    localparam int unsigned CH_BATT    = 0;
    localparam int unsigned CH_BRAKE   = 1;
    localparam int unsigned CH_TORQUE  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } adc_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            prev <= pipe[STAGES-1];
        end
    end

    assign rise_c =  pipe[STAGES-1] & ~prev;
    assign fall_c = ~pipe[STAGES-1] &  prev;

endmodule

// File: rtl/adc128s_model.sv
// SPI slave model of the 8-channel 12-bit ADC with a one-frame address pipeline.
module adc128s_model
    import eBike_adc_pkg::*;
#(
    parameter int unsigned DW             = ADC_DW,
    parameter int unsigned NCH            = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
    input  logic                clk,
    input  logic                RST_n,
    input  logic                SS_n,
    input  logic                SCLK,
    input  logic                MOSI,
    output logic                MISO,
    input  logic [NCH*DW-1:0]   ch_val,
    output logic                frame_done,
    output logic                frame_err,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [2:0]          last_addr
);

    localparam int unsigned PAD = FRAME_BITS - DW;

    logic                   ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   mosi_sync;

    adc_state_t             state, state_nxt;
    logic [FRAME_BITS-1:0]  tx_shft, tx_nxt;
    logic [FRAME_BITS-1:0]  rx_shft, rx_nxt;
    logic [RISE_W-1:0]      rise_cnt, rise_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [2:0]             addr_nxt;
    logic                   done_nxt, err_nxt;
    logic [DW-1:0]          sel_val;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk    (clk),
        .rst_n  (RST_n),
        .din    (SS_n),
        .rise_c (ss_rise),
        .fall_c (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (RST_n),
        .din    (SCLK),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    // MOSI needs only a level synchronizer, matched in depth to SCLK.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) mosi_pipe <= '0;
        else        mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

    // Channel addressed by the previous complete frame.
    assign sel_val = ch_val[32'(last_addr)*DW +: DW];

    // State and datapath registers.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            tx_shft    <= '0;
            rx_shft    <= '0;
            rise_cnt   <= '0;
            frame_cnt  <= FRAME_CNT_INIT;
            last_addr  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx_shft    <= tx_nxt;
            rx_shft    <= rx_nxt;
            rise_cnt   <= rise_nxt;
            frame_cnt  <= cnt_nxt;
            last_addr  <= addr_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
        end
    end

    // Next-state logic; ss edges take priority over any coincident SCLK edge.
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_shft;
        rx_nxt    = rx_shft;
        rise_nxt  = rise_cnt;
        cnt_nxt   = frame_cnt;
        addr_nxt  = last_addr;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    tx_nxt    = {PAD'(0), sel_val};
                    rise_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    if (rise_cnt == RISE_W'(FRAME_BITS)) begin
                        addr_nxt = rx_shft[13:11];
                        cnt_nxt  = frame_cnt + CNT_W'(1);
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    rx_nxt = {rx_shft[FRAME_BITS-2:0], mosi_sync};
                    if (rise_cnt != {RISE_W{1'b1}}) rise_nxt = rise_cnt + RISE_W'(1);
                end else if (sclk_fall && (rise_cnt != '0)) begin
                    tx_nxt = {tx_shft[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign MISO = tx_shft[FRAME_BITS-1];

endmodule
